// File: rtl/mem_ctrl_burst.sv
// Burst SRAM controller: one read/write request per handshake, 1..BURST_MAX beats
// with auto-incrementing address and WAIT_CYCLES idle cycles after every beat.
module mem_ctrl_burst #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int BURST_MAX   = 4,
  parameter int WAIT_CYCLES = 1,
  localparam int LEN_W      = $clog2(BURST_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_WRITE  = 3'd2,
    S_READ   = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state;
  logic                wr_q;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LEN_W-1:0]    beats_left;
  logic [3:0]          wait_cnt;
  logic                beat_done;
  state_t              beat_state;

  // A write beat only completes once the producer has data; a read beat always does.
  always_comb begin
    beat_done  = (state == S_READ) || ((state == S_WRITE) && wdata_valid);
    beat_state = wr_q ? S_WRITE : S_READ;
  end

  // Sequencer: request capture, beat/wait stepping and burst bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wr_q       <= 1'b0;
      cur_addr   <= {ADDR_W{1'b0}};
      beats_left <= {LEN_W{1'b0}};
      wait_cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_q       <= req_wr;
            cur_addr   <= req_addr;
            beats_left <= req_len;
            state      <= S_ACTIVE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACTIVE: state <= beat_state;
        S_WRITE, S_READ: begin
          if (beat_done) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            if (WAIT_CYCLES > 0) begin
              wait_cnt <= 4'(WAIT_CYCLES - 1);
              state    <= S_WAIT;
            end else if (beats_left == {LEN_W{1'b0}}) begin
              state <= S_DONE;
            end else begin
              beats_left <= beats_left - LEN_W'(1);
              state      <= beat_state;
            end
          end else begin
            state <= state;
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (beats_left == {LEN_W{1'b0}}) begin
            state <= S_DONE;
          end else begin
            beats_left <= beats_left - LEN_W'(1);
            state      <= beat_state;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data from the SRAM lands one cycle after the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= (state == S_READ);
    end
  end

  // Output decode from the state register; write strobe/ack qualify on wdata_valid.
  always_comb begin
    req_ready = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    wdata_ack = 1'b0;
    done      = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    case (state)
      S_IDLE:   req_ready = 1'b1;
      S_ACTIVE: mem_cs = 1'b1;
      S_WRITE: begin
        mem_cs    = 1'b1;
        mem_addr  = cur_addr;
        mem_we    = wdata_valid;
        wdata_ack = wdata_valid;
        mem_wdata = wdata;
      end
      S_READ: begin
        mem_cs   = 1'b1;
        mem_re   = 1'b1;
        mem_addr = cur_addr;
      end
      S_WAIT:   mem_cs = 1'b1;
      S_DONE:   done = 1'b1;
      default:  req_ready = 1'b0;
    endcase
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Bench for mem_ctrl_burst: two instances (WAIT_CYCLES=0 and 1) on a behavioural SRAM,
// with a scoreboard of expected write/read strobes and returned read data.
module tb_mem_ctrl_burst;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid[2], req_ready[2], req_wr[2];
  logic [7:0] req_addr[2];
  logic [1:0] req_len[2];
  logic [7:0] wdata[2];
  logic       wdata_valid[2], wdata_ack[2];
  logic [7:0] rdata[2];
  logic       rdata_valid[2], done[2], mem_cs[2], mem_we[2], mem_re[2];
  logic [7:0] mem_addr[2], mem_wdata[2], mem_rdata[2];

  logic [7:0] sram[2][256];
  logic       pl_en;
  int         pl_k;
  logic [7:0] pl_a, pl_d;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] q_wr[$];
  logic [7:0]  q_rd_addr[$];
  logic [7:0]  q_rd_data[$];
  logic [15:0] exp_w;
  logic [7:0]  exp_b;

  always #5 clk = ~clk;

  mem_ctrl_burst #(.ADDR_W(8), .DATA_W(8), .BURST_MAX(4), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_len(req_len[0]),
    .wdata(wdata[0]), .wdata_valid(wdata_valid[0]), .wdata_ack(wdata_ack[0]),
    .rdata(rdata[0]), .rdata_valid(rdata_valid[0]), .done(done[0]),
    .mem_cs(mem_cs[0]), .mem_we(mem_we[0]), .mem_re(mem_re[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_ctrl_burst #(.ADDR_W(8), .DATA_W(8), .BURST_MAX(4), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_len(req_len[1]),
    .wdata(wdata[1]), .wdata_valid(wdata_valid[1]), .wdata_ack(wdata_ack[1]),
    .rdata(rdata[1]), .rdata_valid(rdata_valid[1]), .done(done[1]),
    .mem_cs(mem_cs[1]), .mem_we(mem_we[1]), .mem_re(mem_re[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Behavioural synchronous SRAM per instance, plus a preload port.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) sram[k][mem_addr[k]] <= mem_wdata[k];
      if (mem_re[k]) mem_rdata[k] <= sram[k][mem_addr[k]];
    end
    if (pl_en) sram[pl_k][pl_a] <= pl_d;
  end

  // Scoreboard: every strobe and read return is matched against the expected queues.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k] === 1'b1) begin
        tests_run++;
        if (q_wr.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_write dut%0d: unexpected write addr=%h data=%h, required none", k, mem_addr[k], mem_wdata[k]);
        end else begin
          exp_w = q_wr.pop_front();
          if ({mem_addr[k], mem_wdata[k]} !== exp_w) begin
            tests_failed++;
            $display("FAIL sb_write dut%0d: got addr/data=%h, required %h", k, {mem_addr[k], mem_wdata[k]}, exp_w);
          end
        end
      end
      if (mem_re[k] === 1'b1) begin
        tests_run++;
        if (q_rd_addr.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_read_addr dut%0d: unexpected read addr=%h, required none", k, mem_addr[k]);
        end else begin
          exp_b = q_rd_addr.pop_front();
          if (mem_addr[k] !== exp_b) begin
            tests_failed++;
            $display("FAIL sb_read_addr dut%0d: got %h, required %h", k, mem_addr[k], exp_b);
          end
        end
      end
      if (rdata_valid[k] === 1'b1) begin
        tests_run++;
        if (q_rd_data.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_rdata dut%0d: unexpected rdata=%h, required none", k, rdata[k]);
        end else begin
          exp_b = q_rd_data.pop_front();
          if (rdata[k] !== exp_b) begin
            tests_failed++;
            $display("FAIL sb_rdata dut%0d: got %h, required %h", k, rdata[k], exp_b);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_wr[k] = 1'b0; req_addr[k] = 8'h00; req_len[k] = 2'd0;
      wdata[k] = 8'h00; wdata_valid[k] = 1'b0;
    end
    pl_en = 1'b0; pl_k = 0; pl_a = 8'h00; pl_d = 8'h00;
  endtask

  task automatic preload(input int k, input logic [7:0] a, input logic [7:0] d);
    pl_k = k; pl_a = a; pl_d = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Returns 1 ns after the acceptance edge; the next sample is cycle 1 (ACTIVE).
  task automatic send_req(input int k, input logic wr, input logic [7:0] a, input logic [1:0] len);
    @(posedge clk); #1;
    req_wr[k] = wr; req_addr[k] = a; req_len[k] = len; req_valid[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = 1'($urandom); req_wr[k] = 1'($urandom); req_addr[k] = 8'($urandom);
        req_len[k] = 2'($urandom); wdata[k] = 8'($urandom); wdata_valid[k] = 1'($urandom);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if ({req_ready[k], mem_cs[k], mem_we[k], mem_re[k], done[k], rdata_valid[k], wdata_ack[k], mem_addr[k], mem_wdata[k]} !== {1'b1, 6'b000000, 16'h0000}) begin
          tests_failed++;
          $display("FAIL reset_hold dut%0d: ready/cs/we/re/done/rv/ack=%b%b%b%b%b%b%b addr=%h wd=%h, required 1000000 00 00", k,
                   req_ready[k], mem_cs[k], mem_we[k], mem_re[k], done[k], rdata_valid[k], wdata_ack[k], mem_addr[k], mem_wdata[k]);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    rst = 1'b1;
    // Reset asserted in the middle of a 4-beat read: only the first strobe may occur.
    q_rd_addr.push_back(8'h10);
    send_req(0, 1'b0, 8'h10, 2'd3);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (mem_re[0] !== (c == 2)) begin
        tests_failed++;
        $display("FAIL midreset_pre_re cycle%0d: got %b, required %b", c, mem_re[0], (c == 2));
      end
      if (c == 1) begin @(posedge clk); #1; end
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({req_ready[0], mem_cs[0], mem_re[0], rdata_valid[0]} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL midreset_immediate: ready/cs/re/rv=%b%b%b%b, required 1000", req_ready[0], mem_cs[0], mem_re[0], rdata_valid[0]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests_run++;
      if ({done[0], req_ready[0]} !== 2'b01) begin
        tests_failed++;
        $display("FAIL midreset_after cycle%0d: done/ready=%b%b, required 01", c, done[0], req_ready[0]);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (q_rd_addr.size() + q_rd_data.size() + q_wr.size() != 0) begin
      tests_failed++;
      $display("FAIL midreset_queue: got %0d outstanding, required 0", q_rd_addr.size() + q_rd_data.size() + q_wr.size());
    end
  endtask

  task automatic test_single_write();
    logic [15:0] we_m = 16'h0, ack_m = 16'h0, done_m = 16'h0, rdy_m = 16'h0;
    q_wr.push_back({8'h20, 8'hA5});
    wdata[0] = 8'hA5; wdata_valid[0] = 1'b1;
    send_req(0, 1'b1, 8'h20, 2'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      we_m[c] = mem_we[0]; ack_m[c] = wdata_ack[0]; done_m[c] = done[0]; rdy_m[c] = req_ready[0];
      @(posedge clk); #1;
    end
    wdata_valid[0] = 1'b0;
    tests_run++;
    if ({we_m, ack_m} !== {16'h0004, 16'h0004}) begin
      tests_failed++;
      $display("FAIL write_strobe_timing: we/ack masks=%h/%h, required 0004/0004", we_m, ack_m);
    end
    tests_run++;
    if ({done_m, rdy_m} !== {16'h0008, 16'h0070}) begin
      tests_failed++;
      $display("FAIL write_done_ready: done/ready masks=%h/%h, required 0008/0070", done_m, rdy_m);
    end
    tests_run++;
    if (sram[0][8'h20] !== 8'hA5 || q_wr.size() != 0) begin
      tests_failed++;
      $display("FAIL write_mem: got %h (queue %0d), required a5 (queue 0)", sram[0][8'h20], q_wr.size());
    end
  endtask

  task automatic test_read_burst();
    logic [15:0] re_m = 16'h0, rv_m = 16'h0, done_m = 16'h0;
    logic [7:0]  vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      preload(1, 8'h40 + 8'(i), vals[i]);
      q_rd_addr.push_back(8'h40 + 8'(i));
      q_rd_data.push_back(vals[i]);
    end
    send_req(1, 1'b0, 8'h40, 2'd3);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      re_m[c] = mem_re[1]; rv_m[c] = rdata_valid[1]; done_m[c] = done[1];
      @(posedge clk); #1;
    end
    tests_run++;
    if (re_m !== 16'h0154) begin
      tests_failed++;
      $display("FAIL read_re_timing: mask=%h, required 0154", re_m);
    end
    tests_run++;
    if (rv_m !== 16'h02A8) begin
      tests_failed++;
      $display("FAIL read_rvalid_timing: mask=%h, required 02a8", rv_m);
    end
    tests_run++;
    if (done_m !== 16'h0400) begin
      tests_failed++;
      $display("FAIL read_done: mask=%h, required 0400", done_m);
    end
    tests_run++;
    if (q_rd_addr.size() + q_rd_data.size() != 0) begin
      tests_failed++;
      $display("FAIL read_queue: got %0d outstanding, required 0", q_rd_addr.size() + q_rd_data.size());
    end
  endtask

  task automatic test_write_stall();
    logic [15:0] we_m = 16'h0, ack_m = 16'h0, done_m = 16'h0, cs_m = 16'h0;
    int wr_n = 0;
    q_wr.push_back({8'h30, 8'h5A});
    q_wr.push_back({8'h31, 8'hC3});
    wdata_valid[0] = 1'b0;
    send_req(0, 1'b1, 8'h30, 2'd1);
    for (int c = 1; c <= 10; c++) begin
      wdata_valid[0] = (c >= 5);
      wdata[0] = (wr_n == 0) ? 8'h5A : 8'hC3;
      @(negedge clk);
      we_m[c] = mem_we[0]; ack_m[c] = wdata_ack[0]; done_m[c] = done[0]; cs_m[c] = mem_cs[0];
      if (mem_we[0] === 1'b1) wr_n++;
      @(posedge clk); #1;
    end
    wdata_valid[0] = 1'b0;
    tests_run++;
    if ({we_m, ack_m} !== {16'h0060, 16'h0060}) begin
      tests_failed++;
      $display("FAIL stall_strobes: we/ack masks=%h/%h, required 0060/0060", we_m, ack_m);
    end
    tests_run++;
    if ({done_m, cs_m} !== {16'h0080, 16'h007E}) begin
      tests_failed++;
      $display("FAIL stall_latency: done/cs masks=%h/%h, required 0080/007e", done_m, cs_m);
    end
    tests_run++;
    if ({sram[0][8'h30], sram[0][8'h31]} !== 16'h5AC3 || q_wr.size() != 0) begin
      tests_failed++;
      $display("FAIL stall_mem: got %h%h (queue %0d), required 5ac3 (queue 0)", sram[0][8'h30], sram[0][8'h31], q_wr.size());
    end
  endtask

  task automatic test_addr_wrap();
    logic [15:0] re_m = 16'h0, done_m = 16'h0, rv_m = 16'h0;
    logic [7:0]  addrs[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0]  vals[4]  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      preload(0, addrs[i], vals[i]);
      q_rd_addr.push_back(addrs[i]);
      q_rd_data.push_back(vals[i]);
    end
    send_req(0, 1'b0, 8'hFE, 2'd3);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      re_m[c] = mem_re[0]; done_m[c] = done[0]; rv_m[c] = rdata_valid[0];
      @(posedge clk); #1;
    end
    tests_run++;
    if ({re_m, rv_m} !== {16'h003C, 16'h0078}) begin
      tests_failed++;
      $display("FAIL wrap_timing: re/rv masks=%h/%h, required 003c/0078", re_m, rv_m);
    end
    tests_run++;
    if (done_m !== 16'h0040) begin
      tests_failed++;
      $display("FAIL wrap_done: mask=%h, required 0040", done_m);
    end
    tests_run++;
    if (q_rd_addr.size() + q_rd_data.size() != 0) begin
      tests_failed++;
      $display("FAIL wrap_queue: got %0d outstanding, required 0", q_rd_addr.size() + q_rd_data.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] we_m = 16'h0, re_m = 16'h0, done_m = 16'h0, rdy_m = 16'h0, cs_m = 16'h0;
    q_wr.push_back({8'h55, 8'h3C});
    q_rd_addr.push_back(8'h55);
    q_rd_data.push_back(8'h3C);
    @(posedge clk); #1;
    req_wr[0] = 1'b1; req_addr[0] = 8'h55; req_len[0] = 2'd0; req_valid[0] = 1'b1;
    wdata[0] = 8'h3C; wdata_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_wr[0] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 5) req_valid[0] = 1'b0;
      @(negedge clk);
      we_m[c] = mem_we[0]; re_m[c] = mem_re[0]; done_m[c] = done[0];
      rdy_m[c] = req_ready[0]; cs_m[c] = mem_cs[0];
      @(posedge clk); #1;
    end
    wdata_valid[0] = 1'b0;
    tests_run++;
    if ({we_m, re_m} !== {16'h0004, 16'h0040}) begin
      tests_failed++;
      $display("FAIL b2b_strobes: we/re masks=%h/%h, required 0004/0040", we_m, re_m);
    end
    tests_run++;
    if ({done_m, rdy_m, cs_m} !== {16'h0088, 16'h0310, 16'h0066}) begin
      tests_failed++;
      $display("FAIL b2b_handshake: done/ready/cs masks=%h/%h/%h, required 0088/0310/0066", done_m, rdy_m, cs_m);
    end
    tests_run++;
    if (q_wr.size() + q_rd_addr.size() + q_rd_data.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_queue: got %0d outstanding, required 0", q_wr.size() + q_rd_addr.size() + q_rd_data.size());
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #2;
    test_reset();
    test_single_write();
    test_read_burst();
    test_write_stall();
    test_addr_wrap();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
